vector_mem_stage: RTL and testbench
===================================

Name: vector_mem_stage

Overview:
- MEM stage of the vector pipeline; sits directly upstream of the MEM/WB pipeline register and drives its RD, ALUOut, WA3, RegWrite, MemtoReg and cargar inputs.
- Serialises 8-lane vector loads and stores onto a single-port, one-word-per-cycle data memory, unit stride.
- Stalls the upstream pipeline while an access is in flight.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
- N, 20, lane width in bits.
- AW, 10, data-memory word-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- MemRead  in  1  vector load request; also the MemtoReg flag.
- MemWrite  in  1  vector store request.
- RegWrite  in  1  register write enable from EX/MEM.
- WA3  in  4  destination vector register.
- Addr  in  AW  base word address.
- WD  in  8xN  store data, lane k = WD[k].
- ALUOut  in  8xN  ALU result.
- mem_rdata  in  N  memory read data, valid one cycle after a read request.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  1 = write.
- mem_addr  out  AW  word address.
- mem_wdata  out  N  write data.
- stall  out  1  hold EX/MEM and upstream stages.
- RDW  out  8xN  to MEM/WB RD.
- ALUOutW  out  8xN  to MEM/WB ALUOut.
- WA3W  out  4  to MEM/WB WA3.
- RegWriteW  out  1  to MEM/WB RegWrite.
- MemtoRegW  out  1  to MEM/WB MemtoReg.
- cargar_wb  out  1  to MEM/WB cargar; 1 = load this cycle.

Behaviour:
- Reset:
  - State is IDLE, lane counter is 0, and the 8xN load buffer and all latched fields are 0.
  - While reset = 0, all outputs are 0, including stall and cargar_wb.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE, no memory op (MemRead = 0 and MemWrite = 0):
  - ALUOutW = ALUOut, WA3W = WA3, RegWriteW = RegWrite, MemtoRegW = 0, RDW = 0.
  - cargar_wb = 1, stall = 0, mem_req = 0.
- IDLE, memory op (cycle 0):
  - Latch WA3, RegWrite, Addr, WD, ALUOut and the op type.
  - MemWrite has priority if both requests are 1: the op is treated as a store, MemtoRegW = 0 and RDW = 0.
  - Issue lane 0 with mem_req = 1 and mem_addr = Addr.
  - stall = 1, cargar_wb = 0. Next state is ISSUE with counter = 1.
- ISSUE (counter k = 1..7):
  - mem_req = 1, mem_addr = (Addr + k) mod 2^AW, so the address wraps at 2^AW - 1 to 0.
  - Store: mem_we = 1 and mem_wdata = WD[k]. Load: mem_we = 0, and mem_rdata is captured into buffer[k-1] each cycle.
  - stall = 1, cargar_wb = 0.
  - After k = 7: a load goes to CAPTURE, a store goes to DONE.
- Lane-0 write and counter:
  - The lane-0 store write (mem_we = 1, mem_wdata = WD[0]) happens in cycle 0.
  - The counter is 3 bits and never exceeds 7.
- CAPTURE (loads only, cycle 8):
  - mem_req = 0 and buffer[7] = mem_rdata.
  - stall = 1, cargar_wb = 0. Next state is DONE.
- DONE:
  - RDW = buffer (all 0 for stores). ALUOutW, WA3W and RegWriteW come from the latched values; MemtoRegW = 1 only for loads.
  - cargar_wb = 1, stall = 0.
  - Next state is IDLE, and the new EX/MEM contents are evaluated there on the following cycle.
- Latency:
  - Load: stall is high for cycles 0..8 and the result is delivered in cycle 9.
  - Store: stall is high for cycles 0..7 and the result is delivered in cycle 8.
- Memory ops in flight: MemRead and MemWrite are ignored outside IDLE.
- Reset mid-operation:
  - The FSM aborts to IDLE immediately (asynchronously) and mem_req drops to 0.
  - A partial store is not rolled back, and buffered load data is discarded.

Test Plan:
- Pass-through: MemRead = MemWrite = 0, ALUOut lane 3 = 20'h0ABCD, WA3 = 5, RegWrite = 1 -> same cycle: ALUOutW[3] = 20'h0ABCD, WA3W = 5, cargar_wb = 1, stall = 0, mem_req = 0.
- Load: Addr = 16, memory word at 16+k = k+100 -> mem_addr = 16..23 on cycles 0..7; stall high for 9 cycles; cycle 9: RDW[k] = k+100, MemtoRegW = 1, cargar_wb = 1.
- Store wrap: Addr = 1020, AW = 10, WD[k] = k+1 -> writes go to addresses 1020, 1021, 1022, 1023, 0, 1, 2, 3 with data 1..8; cargar_wb = 1 only in cycle 8, RDW = 0.
- Conflict: MemRead = MemWrite = 1 -> executes as a store, MemtoRegW = 0, RDW = 0, 8-cycle stall.
- Reset mid-load: drive reset = 0 during cycle 4 of a load -> mem_req, stall and cargar_wb drop to 0 immediately without waiting for a clock edge; after release, a pass-through op completes normally with RDW = 0.
- Back-to-back: two loads presented consecutively -> the second starts in the cycle after DONE; two complete 10-cycle sequences, each with exactly one cargar_wb pulse.

Source files
------------

// File: rtl/vector_mem_stage.sv
// vector_mem_stage: MEM stage of the vector pipeline.
// Serialises 8-lane unit-stride vector loads/stores onto a single-port data memory that
// moves one N-bit word per cycle, stalling upstream while the access is in flight.
// Non-memory instructions pass straight through to the MEM/WB register with no latency.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite   vector load / store request (MemWrite wins if both set)
//   RegWrite, WA3       register write enable and destination vector register
//   Addr                base word address of the vector
//   WD, ALUOut          store data and ALU result, 8 lanes of N bits
//   mem_*               single-port data memory; mem_rdata valid one cycle after a read
//   stall               hold EX/MEM and upstream stages
//   RDW..cargar_wb      inputs of the MEM/WB register; cargar_wb = 1 loads it this cycle
module vector_mem_stage #(
  parameter int unsigned N  = 20,
  parameter int unsigned AW = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                RegWrite,
  input  logic [3:0]          WA3,
  input  logic [AW-1:0]       Addr,
  input  logic [7:0][N-1:0]   WD,
  input  logic [7:0][N-1:0]   ALUOut,
  input  logic [N-1:0]        mem_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [N-1:0]        mem_wdata,
  output logic                stall,
  output logic [7:0][N-1:0]   RDW,
  output logic [7:0][N-1:0]   ALUOutW,
  output logic [3:0]          WA3W,
  output logic                RegWriteW,
  output logic                MemtoRegW,
  output logic                cargar_wb
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [7:0][N-1:0]   buf_q, buf_d;
  logic [7:0][N-1:0]   wd_q, wd_d;
  logic [7:0][N-1:0]   alu_q, alu_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [3:0]          wa3_q, wa3_d;
  logic                rw_q, rw_d;
  logic                is_load_q, is_load_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      buf_q     <= '0;
      wd_q      <= '0;
      alu_q     <= '0;
      addr_q    <= '0;
      wa3_q     <= '0;
      rw_q      <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      wd_q      <= wd_d;
      alu_q     <= alu_d;
      addr_q    <= addr_d;
      wa3_q     <= wa3_d;
      rw_q      <= rw_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    wd_d      = wd_q;
    alu_d     = alu_q;
    addr_d    = addr_q;
    wa3_d     = wa3_q;
    rw_d      = rw_q;
    is_load_d = is_load_q;

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    RDW       = '0;
    ALUOutW   = '0;
    WA3W      = '0;
    RegWriteW = 1'b0;
    MemtoRegW = 1'b0;
    cargar_wb = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (MemRead || MemWrite) begin
          // Cycle 0: latch the instruction and issue lane 0 directly from the inputs.
          wd_d      = WD;
          alu_d     = ALUOut;
          addr_d    = Addr;
          wa3_d     = WA3;
          rw_d      = RegWrite;
          is_load_d = !MemWrite;
          cnt_d     = 3'd1;
          state_d   = StIssue;
          mem_req   = 1'b1;
          mem_we    = MemWrite;
          mem_addr  = Addr;
          mem_wdata = MemWrite ? WD[0] : '0;
          stall     = 1'b1;
        end else begin
          ALUOutW   = ALUOut;
          WA3W      = WA3;
          RegWriteW = RegWrite;
          cargar_wb = 1'b1;
        end
      end
      StIssue: begin
        mem_req  = 1'b1;
        // Address arithmetic truncates to AW bits, so the vector wraps at the top of memory.
        mem_addr = addr_q + AW'(cnt_q);
        stall    = 1'b1;
        if (is_load_q) begin
          // Read data lags its request by one cycle, so lane k-1 arrives while lane k issues.
          buf_d[cnt_q - 3'd1] = mem_rdata;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = wd_q[cnt_q];
        end
        if (cnt_q == 3'd7) begin
          cnt_d   = '0;
          state_d = is_load_q ? StCapture : StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StCapture: begin
        buf_d[7] = mem_rdata;
        stall    = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        RDW       = is_load_q ? buf_q : '0;
        ALUOutW   = alu_q;
        WA3W      = wa3_q;
        RegWriteW = rw_q;
        MemtoRegW = is_load_q;
        cargar_wb = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Idle outputs depend on live inputs, so they must be forced quiet while reset is held.
    if (!reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall     = 1'b0;
      RDW       = '0;
      ALUOutW   = '0;
      WA3W      = '0;
      RegWriteW = 1'b0;
      MemtoRegW = 1'b0;
      cargar_wb = 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_mem_stage.sv
module tb_vector_mem_stage;
  localparam int N  = 20;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead, MemWrite, RegWrite;
  logic [3:0]        WA3;
  logic [AW-1:0]     Addr;
  logic [7:0][N-1:0] WD, ALUOut;
  logic [N-1:0]      mem_rdata;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [N-1:0]      mem_wdata;
  logic              stall;
  logic [7:0][N-1:0] RDW, ALUOutW;
  logic [3:0]        WA3W;
  logic              RegWriteW, MemtoRegW, cargar_wb;

  always #5 clk = ~clk;

  vector_mem_stage #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .WA3(WA3), .Addr(Addr), .WD(WD), .ALUOut(ALUOut), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .RDW(RDW), .ALUOutW(ALUOutW), .WA3W(WA3W), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .cargar_wb(cargar_wb)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [N-1:0]  data;
  } acc_t;

  typedef struct {
    logic [7:0][N-1:0] rdw;
    logic [7:0][N-1:0] alu;
    logic [3:0]        wa3;
    logic              rw;
    logic              m2r;
  } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];
  logic [N-1:0] phys_mem [0:1023];  // memory seen by the DUT
  logic [N-1:0] ref_mem  [0:1023];  // reference contents, updated when a store is issued
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (reset && mem_req) begin
      if (mem_we) phys_mem[mem_addr] = mem_wdata;
      else mem_rdata <= phys_mem[mem_addr];
    end
  end

  // Monitor: every memory access and every MEM/WB load is matched against the scoreboard.
  acc_t ma;
  res_t mr;
  always @(negedge clk) begin
    if (mem_req) begin
      if (exp_acc.size() == 0) check("unexpected_mem_req", mem_req, 1'b0);
      else begin
        ma = exp_acc.pop_front();
        check("mem_addr", mem_addr, ma.addr);
        check("mem_we", mem_we, ma.we);
        if (ma.we) check("mem_wdata", mem_wdata, ma.data);
      end
    end
    if (cargar_wb) begin
      if (exp_res.size() == 0) check("unexpected_cargar_wb", cargar_wb, 1'b0);
      else begin
        mr = exp_res.pop_front();
        check("RDW", RDW, mr.rdw);
        check("ALUOutW", ALUOutW, mr.alu);
        check("WA3W", WA3W, mr.wa3);
        check("RegWriteW", RegWriteW, mr.rw);
        check("MemtoRegW", MemtoRegW, mr.m2r);
      end
    end
  end

  function automatic logic [7:0][N-1:0] rand_vec();
    logic [7:0][N-1:0] v;
    for (int k = 0; k < 8; k++) v[k] = N'($urandom);
    return v;
  endfunction

  // Present one instruction and hold it until the stage accepts it (stall low).
  task automatic do_op(input logic rd, input logic wr, input logic [3:0] wa3, input logic rw,
                       input logic [AW-1:0] addr, input logic [7:0][N-1:0] wd,
                       input logic [7:0][N-1:0] alu);
    res_t r;
    acc_t a;
    logic [AW-1:0] ak;
    int stalls;
    bit ld;
    ld    = rd && !wr;
    r.rdw = '0;
    r.alu = alu;
    r.wa3 = wa3;
    r.rw  = rw;
    r.m2r = ld;
    if (rd || wr) begin
      for (int k = 0; k < 8; k++) begin
        ak     = addr + AW'(k);
        a.addr = ak;
        a.we   = wr;
        a.data = wd[k];
        exp_acc.push_back(a);
        if (ld) r.rdw[k] = ref_mem[ak];
        if (wr) ref_mem[ak] = wd[k];
      end
    end
    exp_res.push_back(r);
    MemRead = rd; MemWrite = wr; WA3 = wa3; RegWrite = rw; Addr = addr; WD = wd; ALUOut = alu;
    stalls = 0;
    do begin
      @(negedge clk);
      if (stall) stalls++;
    end while (stall && stalls < 50);
    check("stall_cycles", stalls, ld ? 9 : (wr ? 8 : 0));
    @(posedge clk);
    #1;
  endtask

  logic [7:0][N-1:0] v;
  acc_t ra;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      phys_mem[i] = N'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    for (int k = 0; k < 8; k++) begin
      phys_mem[16 + k] = N'(k + 100);
      ref_mem[16 + k]  = N'(k + 100);
    end
    mem_rdata = '0;

    // Reset held with a live pass-through instruction: every output must stay 0.
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1; WA3 = 4'd9;
    Addr = 10'd7; WD = rand_vec(); ALUOut = rand_vec();
    @(negedge clk);
    check("rst_cargar_wb", cargar_wb, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ALUOutW", ALUOutW, '0);
    check("rst_WA3W", WA3W, '0);
    check("rst_RegWriteW", RegWriteW, 1'b0);
    check("rst_RDW", RDW, '0);
    @(posedge clk); #1 reset = 1'b1;

    // Directed pass-through.
    v = rand_vec(); v[3] = 20'h0ABCD;
    do_op(1'b0, 1'b0, 4'd5, 1'b1, 10'd0, rand_vec(), v);
    // Directed load from 16..23.
    do_op(1'b1, 1'b0, 4'd2, 1'b1, 10'd16, rand_vec(), rand_vec());
    // Store wrapping past the top of memory.
    for (int k = 0; k < 8; k++) v[k] = N'(k + 1);
    do_op(1'b0, 1'b1, 4'd3, 1'b0, 10'd1020, v, rand_vec());
    // Conflicting requests execute as a store.
    do_op(1'b1, 1'b1, 4'd7, 1'b1, 10'd500, rand_vec(), rand_vec());
    // Back-to-back loads, the first reading back the wrapped store.
    do_op(1'b1, 1'b0, 4'd8, 1'b1, 10'd1020, rand_vec(), rand_vec());
    do_op(1'b1, 1'b0, 4'd9, 1'b1, 10'd16, rand_vec(), rand_vec());

    // Reset asserted during cycle 4 of a load.
    for (int k = 0; k < 8; k++) begin
      ra.addr = AW'(300 + k); ra.we = 1'b0; ra.data = '0;
      exp_acc.push_back(ra);
    end
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 10'd300;
    repeat (4) @(posedge clk);
    #2;
    check("stall_before_abort", stall, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_cargar_wb", cargar_wb, 1'b0);
    exp_acc.delete();
    MemRead = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    do_op(1'b0, 1'b0, 4'd4, 1'b1, 10'd0, rand_vec(), rand_vec());

    // Randomised mix of pass-through, load, store and conflicting requests.
    for (int i = 0; i < 40; i++) begin
      int t;
      t = $urandom_range(0, 3);
      do_op(t[0], t[1], 4'($urandom), 1'($urandom), AW'($urandom), rand_vec(), rand_vec());
    end

    reset = 1'b0;
    #1;
    check("acc_queue_drained", exp_acc.size(), 0);
    check("res_queue_drained", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
